// File: rtl/change_dispenser.sv
// ==== change_dispenser : greedy half-penny / farthing change dispenser FSM ==== Rev 1.0 ====
`default_nettype none

module change_dispenser #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_change_q,
  input  logic       i_dispense_ack,
  input  logic       i_fault_clr,
  output logic       o_eject_half,
  output logic       o_eject_farthing,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fault,
  output logic [3:0] o_remaining,
  output logic [2:0] o_half_count,
  output logic [1:0] o_farthing_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_EJECT    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_GAP      = 3'd4,
    S_DONE     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  localparam logic [3:0] c_GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] c_TO_LAST  = 8'(ACK_TIMEOUT - 1);

  state_t     r_state;
  logic       r_eject_half;
  logic       r_eject_farthing;
  logic       r_busy;
  logic       r_done;
  logic       r_fault;
  logic [3:0] r_remaining;
  logic [2:0] r_half_count;
  logic [1:0] r_farthing_count;
  logic [7:0] r_to_cnt;
  logic [3:0] r_gap_cnt;

  logic       w_pick_half;

  // EJECT is only reached with remaining != 0, so a farthing is issued only at remaining == 1
  assign w_pick_half = (r_remaining >= 4'd2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_eject_half     <= 1'b0;
      r_eject_farthing <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_fault          <= 1'b0;
      r_remaining      <= 4'd0;
      r_half_count     <= 3'd0;
      r_farthing_count <= 2'd0;
      r_to_cnt         <= 8'd0;
      r_gap_cnt        <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_remaining      <= i_change_q;
            r_half_count     <= 3'd0;
            r_farthing_count <= 2'd0;
            r_busy           <= 1'b1;
            r_state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_remaining == 4'd0) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_EJECT;
          end
        end
        S_EJECT: begin
          r_eject_half     <= w_pick_half;
          r_eject_farthing <= ~w_pick_half;
          r_to_cnt         <= 8'd0;
          r_state          <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // Acknowledge is tested first so it wins over a coincident timeout
          if (i_dispense_ack) begin
            r_eject_half     <= 1'b0;
            r_eject_farthing <= 1'b0;
            if (r_eject_half) begin
              r_remaining  <= r_remaining - 4'd2;
              r_half_count <= r_half_count + 3'd1;
            end else begin
              r_remaining      <= r_remaining - 4'd1;
              r_farthing_count <= r_farthing_count + 2'd1;
            end
            r_gap_cnt <= 4'd0;
            r_state   <= S_GAP;
          end else if (r_to_cnt == c_TO_LAST) begin
            r_eject_half     <= 1'b0;
            r_eject_farthing <= 1'b0;
            r_fault          <= 1'b1;
            r_state          <= S_FAULT;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            if (r_remaining == 4'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_EJECT;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          if (i_fault_clr) begin
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_eject_half     <= 1'b0;
          r_eject_farthing <= 1'b0;
          r_busy           <= 1'b0;
          r_fault          <= 1'b0;
          r_state          <= S_IDLE;
        end
      endcase
    end
  end

  assign o_eject_half     = r_eject_half;
  assign o_eject_farthing = r_eject_farthing;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_fault          = r_fault;
  assign o_remaining      = r_remaining;
  assign o_half_count     = r_half_count;
  assign o_farthing_count = r_farthing_count;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ==== tb_change_dispenser : directed self-checking bench for change_dispenser ==== Rev 1.0 ====
`default_nettype none

module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic [3:0] change_q = 4'd0;
  logic       ack = 1'b0;
  logic       fault_clr = 1'b0;
  logic       eject_half, eject_farthing, busy, done, fault;
  logic [3:0] remaining;
  logic [2:0] half_count;
  logic [1:0] farthing_count;

  int errors = 0;
  int checks = 0;

  logic [3:0] rem_log [0:15];
  int         rem_n;

  change_dispenser #(.GAP_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_change_q       (change_q),
    .i_dispense_ack   (ack),
    .i_fault_clr      (fault_clr),
    .o_eject_half     (eject_half),
    .o_eject_farthing (eject_farthing),
    .o_busy           (busy),
    .o_done           (done),
    .o_fault          (fault),
    .o_remaining      (remaining),
    .o_half_count     (half_count),
    .o_farthing_count (farthing_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction, acking each eject on its first cycle; returns observations at the done pulse.
  task automatic dispense(input logic [3:0] q, output int nh, output int nf, output int gmin,
                          output int gmax, output int lat, output bit bad, output bit tmo);
    int low;
    bit seen;
    nh = 0; nf = 0; gmin = 1000; gmax = 0; lat = 0; bad = 0; tmo = 1; low = 0; seen = 0;
    rem_n = 0;
    change_q = q; start = 1'b1;
    step();
    start = 1'b0; lat = 1;
    for (int c = 0; c < 400; c++) begin
      if (done) begin tmo = 0; break; end
      if (eject_half || eject_farthing) begin
        if (eject_half && eject_farthing) bad = 1;
        if (eject_farthing && remaining != 4'd1) bad = 1;
        if (eject_half && nf != 0) bad = 1;
        if (seen) begin
          if (low < gmin) gmin = low;
          if (low > gmax) gmax = low;
        end
        seen = 1; low = 0;
        if (eject_half) nh++; else nf++;
        ack = 1'b1;
        step();
        ack = 1'b0; lat++;
        rem_log[rem_n] = remaining; rem_n++;
      end else begin
        low++;
        step();
        lat++;
      end
    end
  endtask

  task automatic finish_txn(output bit got_done);
    got_done = 0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin got_done = 1; break; end
      ack = (eject_half || eject_farthing);
      step();
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({eject_half, eject_farthing, busy, done, fault, remaining, half_count, farthing_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {eject_half, eject_farthing, busy, done, fault, remaining, half_count, farthing_count});
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_q5();
    int nh, nf, gmin, gmax, lat; bit bad, tmo;
    dispense(4'd5, nh, nf, gmin, gmax, lat, bad, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL q5_done_seen: got timeout=%0d expected 0", tmo); end
    checks++;
    if (nh != 2 || nf != 1) begin errors++; $display("FAIL q5_ejects: got half=%0d farthing=%0d expected 2/1", nh, nf); end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL q5_eject_order: got bad=%0d expected 0", bad); end
    checks++;
    if (rem_n != 3 || rem_log[0] !== 4'd3 || rem_log[1] !== 4'd1 || rem_log[2] !== 4'd0) begin
      errors++;
      $display("FAIL q5_remaining_seq: got n=%0d %0d,%0d,%0d expected 3,1,0", rem_n, rem_log[0], rem_log[1], rem_log[2]);
    end
    // Low cycles between ejects: four GAP cycles plus the EJECT selection cycle
    checks++;
    if (gmin != 5 || gmax != 5) begin errors++; $display("FAIL q5_gap: got min=%0d max=%0d expected 5", gmin, gmax); end
    checks++;
    if (half_count !== 3'd2 || farthing_count !== 2'd1 || remaining !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL q5_final: got hc=%0d fc=%0d rem=%0d busy=%b expected 2/1/0/1", half_count, farthing_count, remaining, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || half_count !== 3'd2 || farthing_count !== 2'd1) begin
      errors++;
      $display("FAIL q5_after_done: got done=%b busy=%b hc=%0d fc=%0d expected 0/0/2/1", done, busy, half_count, farthing_count);
    end
  endtask

  task automatic test_zero();
    int nh, nf, gmin, gmax, lat; bit bad, tmo;
    dispense(4'd0, nh, nf, gmin, gmax, lat, bad, tmo);
    checks++;
    if (tmo !== 1'b0 || lat != 2) begin errors++; $display("FAIL zero_latency: got lat=%0d tmo=%0d expected 2/0", lat, tmo); end
    checks++;
    if (nh + nf != 0) begin errors++; $display("FAIL zero_no_eject: got %0d ejects expected 0", nh + nf); end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_idle: got done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_q15();
    int nh, nf, gmin, gmax, lat; bit bad, tmo;
    dispense(4'd15, nh, nf, gmin, gmax, lat, bad, tmo);
    checks++;
    if (tmo !== 1'b0 || nh != 7 || nf != 1 || bad !== 1'b0) begin
      errors++;
      $display("FAIL q15_ejects: got half=%0d farthing=%0d bad=%0d tmo=%0d expected 7/1/0/0", nh, nf, bad, tmo);
    end
    checks++;
    if (half_count !== 3'd7 || farthing_count !== 2'd1 || remaining !== 4'd0) begin
      errors++;
      $display("FAIL q15_counts: got hc=%0d fc=%0d rem=%0d expected 7/1/0", half_count, farthing_count, remaining);
    end
    step();
  endtask

  task automatic test_ack_hold();
    bit got;
    change_q = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++;
    if (eject_half !== 1'b1) begin errors++; $display("FAIL hold_eject: got %b expected 1", eject_half); end
    ack = 1'b1;
    step(); step(); step();
    ack = 1'b0;
    checks++;
    if (remaining !== 4'd2 || half_count !== 3'd1) begin
      errors++;
      $display("FAIL hold_single_decrement: got rem=%0d hc=%0d expected 2/1", remaining, half_count);
    end
    finish_txn(got);
    checks++;
    if (!got || half_count !== 3'd2 || remaining !== 4'd0) begin
      errors++;
      $display("FAIL hold_complete: got done=%0d hc=%0d rem=%0d expected 1/2/0", got, half_count, remaining);
    end
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    change_q = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    while (!fault && n < 50) begin
      if (eject_half) n++;
      step();
    end
    checks++;
    if (n != 8 || fault !== 1'b1) begin errors++; $display("FAIL timeout_cycles: got %0d fault=%b expected 8/1", n, fault); end
    checks++;
    if (eject_half !== 1'b0 || remaining !== 4'd3 || busy !== 1'b1 || half_count !== 3'd0) begin
      errors++;
      $display("FAIL fault_state: got eh=%b rem=%0d busy=%b hc=%0d expected 0/3/1/0", eject_half, remaining, busy, half_count);
    end
    ack = 1'b1;
    step(); step();
    ack = 1'b0;
    step();
    checks++;
    if (fault !== 1'b1 || remaining !== 4'd3 || eject_half !== 1'b0) begin
      errors++;
      $display("FAIL fault_frozen: got fault=%b rem=%0d eh=%b expected 1/3/0", fault, remaining, eject_half);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fault_clear: got fault=%b busy=%b expected 0/0", fault, busy); end
  endtask

  task automatic test_ack_race();
    bit got;
    change_q = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    repeat (7) step();
    checks++;
    if (eject_farthing !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL race_last_wait: got ef=%b fault=%b expected 1/0", eject_farthing, fault);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    checks++;
    if (fault !== 1'b0 || eject_farthing !== 1'b0 || remaining !== 4'd0 || farthing_count !== 2'd1) begin
      errors++;
      $display("FAIL race_ack_wins: got fault=%b ef=%b rem=%0d fc=%0d expected 0/0/0/1", fault, eject_farthing, remaining, farthing_count);
    end
    finish_txn(got);
    checks++;
    if (!got) begin errors++; $display("FAIL race_done: got %0d expected 1", got); end
    step();
  endtask

  task automatic test_restart_ignored();
    bit got;
    change_q = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    change_q = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (remaining !== 4'd2 || eject_half !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored: got rem=%0d eh=%b expected 2/1", remaining, eject_half);
    end
    finish_txn(got);
    checks++;
    if (!got || half_count !== 3'd1 || farthing_count !== 2'd0 || remaining !== 4'd0) begin
      errors++;
      $display("FAIL restart_complete: got done=%0d hc=%0d fc=%0d rem=%0d expected 1/1/0/0", got, half_count, farthing_count, remaining);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit quiet = 1;
    int nh, nf, gmin, gmax, lat; bit bad, tmo;
    change_q = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++;
    if (eject_half !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got eh=%b expected 1", eject_half); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (eject_half !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_async: got eh=%b busy=%b rem=%0d expected 0/0/0", eject_half, busy, remaining);
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ack = i[0];
      step();
      if (busy || eject_half || eject_farthing || remaining != 4'd0 || half_count != 3'd0) quiet = 0;
    end
    ack = 1'b0;
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL rstmid_no_resume: got quiet=%0d expected 1", quiet); end
    dispense(4'd2, nh, nf, gmin, gmax, lat, bad, tmo);
    checks++;
    if (tmo !== 1'b0 || nh != 1 || nf != 0) begin
      errors++;
      $display("FAIL rstmid_new_txn: got half=%0d farthing=%0d tmo=%0d expected 1/0/0", nh, nf, tmo);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_q5();
    test_zero();
    test_q15();
    test_ack_hold();
    test_timeout();
    test_ack_race();
    test_restart_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
